// File: rtl/ahb_slv_pkg.sv
// Shared types for the AHB-Lite register-file slave: bus encodings, FSM states, data width.
package ahb_slv_pkg;

    localparam int AHB_DW = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

endpackage

// File: rtl/ahb_slv_wait_cnt.sv
// Wait-state down-counter: loaded on entry to WAIT, done_o flags the last wait cycle.
module ahb_slv_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/ahb_slv_regfile.sv
// AHB-Lite leaf slave mapping single transfers onto NUM_REGS 32-bit registers (reg 0 = ID).
// Optional macro AHB_SLV_HPROT_CHK_EN: user-mode writes (hprot[1]=0) take the ERROR path.
module ahb_slv_regfile
    import ahb_slv_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                       hclk,
    input  logic                       hrst_n,
    input  logic                       hsel,
    input  logic [31:0]                haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [3:0]                 hprot,
    input  logic [AHB_DW-1:0]          hwdata,
    output logic [AHB_DW-1:0]          hrdata,
    output logic                       hready,
    output logic [1:0]                 hresp,
    output logic [NUM_REGS*AHB_DW-1:0] regs_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    slv_state_e        state_q, state_d;
    htrans_e           trans;
    logic [IDX_W-1:0]  idx_q, idx_d, addr_idx, rd_idx;
    logic              wr_q, wr_d;
    logic              accept, illegal, cnt_load, cnt_done, rd_load;
    logic [AHB_DW-1:0] rd_val, hrdata_q, hrdata_d;
    logic [AHB_DW-1:0] regs_q [1:NUM_REGS-1];
    logic              unused_hprot;

    assign trans    = htrans_e'(htrans);
    assign addr_idx = haddr[2 +: IDX_W];
    assign accept   = hsel && hready && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

    always_comb begin
        illegal = (haddr[1:0] != 2'b00)
               || ({2'b00, haddr[31:2]} >= 32'(NUM_REGS))
               || (hwrite && (haddr[31:2] == '0));
`ifdef AHB_SLV_HPROT_CHK_EN
        if (hwrite && !hprot[1]) begin
            illegal = 1'b1;
        end
`endif
    end

`ifdef AHB_SLV_HPROT_CHK_EN
    assign unused_hprot = ^{hprot[3:2], hprot[0]};
`else
    assign unused_hprot = ^hprot;
`endif

    ahb_slv_wait_cnt #(.W(4)) u_wait_cnt (
        .clk_i      (hclk),
        .rst_ni     (hrst_n),
        .load_i     (cnt_load),
        .load_val_i (4'(WAIT_STATES)),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        cnt_load = 1'b0;
        rd_load  = 1'b0;
        rd_idx   = idx_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_done) begin
                    state_d = ST_DATA;
                    rd_load = !wr_q;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d  = addr_idx;
                    wr_d   = hwrite;
                    rd_idx = addr_idx;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                        rd_load = !hwrite;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A read accepted while a write closes its data phase sees the committing hwdata.
    always_comb begin
        rd_val = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
        if (state_q == ST_DATA && wr_q && idx_q == rd_idx) begin
            rd_val = hwdata;
        end
        hrdata_d = rd_load ? rd_val : hrdata_q;
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == ST_DATA && wr_q) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    regs_q[i] <= hwdata;
                end
            end
        end
    end

    always_comb begin
        regs_o = '0;
        regs_o[AHB_DW-1:0] = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_o[AHB_DW*i +: AHB_DW] = regs_q[i];
        end
    end

    assign hready = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign hresp  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata = hrdata_q;

endmodule

// File: doc/ahb_slv_regfile.md
Name: ahb_slv_regfile

Overview:
- AHB-Lite responder that terminates single transfers from an AHB initiator and maps them onto a bank of 32-bit registers.
- Supports a programmable number of wait states and a two-cycle ERROR response for illegal accesses.
- Sits behind the bus decoder as a leaf slave. It is the DUT-side counterpart used with the team's AHB agent interface.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; legal range 2..256.
- WAIT_STATES, 0, hready-low cycles inserted in every OKAY data phase; range 0..15.
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0, which is read-only.

Ports:
- hclk  input  1  bus clock; all logic on its rising edge.
- hrst_n  input  1  reset, asynchronous assert, active-low.
- hsel  input  1  slave select.
- haddr  input  32  byte address; bits [1:0] must be 0.
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  input  1  1 = write.
- hprot  input  4  protection; used only with the optional feature.
- hwdata  input  32  write data, valid in data phase.
- hrdata  output  32  read data, registered.
- hready  output  1  transfer-done / slave ready.
- hresp  output  2  OKAY=2'b00, ERROR=2'b01.
- regs_o  output  NUM_REGS*32  flattened register contents, reg i at [32*i+:32]; reg 0 shows ID_VALUE.

Behaviour:
- Clock and reset:
  - One clock, hclk. Reset hrst_n is asynchronous and active-low.
  - Reset values: hready=1, hresp=OKAY, hrdata=0, state=IDLE, regs[1..N-1]=0.
  - Reset mid-transfer aborts it: no register update, outputs return to their reset values immediately.
- Address phase:
  - A transfer is accepted at a rising edge where hsel=1, htrans[1]=1 and hready=1.
  - On acceptance, index=haddr[2+:$clog2(NUM_REGS)] and hwrite are registered.
  - BUSY or IDLE htrans is ignored and leaves outputs unchanged.
- Illegal access: any of the following at acceptance produces an ERROR.
  - haddr[1:0]!=0.
  - haddr[31:2] >= NUM_REGS.
  - Write to register 0.
- FSM states:
  - IDLE: hready=1, hresp=OKAY.
    - Accepted legal transfer with WAIT_STATES=0 -> DATA.
    - Accepted legal transfer with WAIT_STATES>0 -> WAIT, loading wait counter = WAIT_STATES.
    - Accepted illegal transfer -> ERR1.
  - WAIT: hready=0, hresp=OKAY. Counter decrements each cycle; at 1 -> DATA.
  - DATA: hready=1, hresp=OKAY; the data phase completes at the end of this cycle.
    - Write: regs[index] <= hwdata at the closing edge.
    - Read: hrdata is loaded on the edge entering DATA, so it is valid throughout the hready=1 cycle.
    - A new transfer may be accepted at the same closing edge (pipelined); next state is chosen as from IDLE. Otherwise -> IDLE.
  - ERR1: hready=0, hresp=ERROR -> ERR2.
  - ERR2: hready=1, hresp=ERROR. No register write; hrdata is unchanged. A transfer accepted here is processed as from IDLE; otherwise -> IDLE.
- hrdata holding: hrdata holds its last read value until the next read reaches DATA. Writes and errors never alter it, because initiators may sample it one cycle after hready.
- Latency (first hready=1 after acceptance):
  - Read: WAIT_STATES+1 cycles.
  - Write: WAIT_STATES+1 cycles.
  - Error: 2 cycles.
- Back-to-back write then read of the same register: the read returns the new value (write commits before read data is loaded).
- hsel dropping during a data phase does not cancel the transfer.

Optional Feature:
- Macro AHB_SLV_HPROT_CHK_EN.
- Defined: an accepted write with hprot[1]=0 (user mode) is an illegal access and takes the ERR1/ERR2 path; reads are unaffected.
- Undefined: hprot is ignored entirely (no logic, lint waiver for unused input).

Decomposition:
- Package ahb_slv_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ).
  - hresp_e (OKAY/ERROR).
  - Slave FSM state enum slv_state_e.
  - Constant AHB_DW=32.
- One natural sub-module, ahb_slv_wait_cnt: the wait-state down-counter with load and done outputs. Everything else stays in the top.

Test Plan:
- WAIT_STATES=0: write 0x0000_0008 <- 32'hDEAD_BEEF, then read 0x8 -> hready never low; hresp=OKAY; hrdata=DEADBEEF in the DATA cycle and still DEADBEEF one cycle later.
- WAIT_STATES=3: read 0x0 -> exactly 3 cycles hready=0, then hrdata=A5B00001 with OKAY.
- Write to 0x0, to 0x41 (unaligned), and to 0x40 with NUM_REGS=16 (out of range) -> each gives a two-cycle ERROR (hready 0 then 1, hresp=01); regs_o unchanged.
- Back-to-back write 0x4 <- 32'h1234 then read 0x4 in the next address phase -> read returns 00001234; total 3 cycles at WAIT_STATES=0.
- Assert hrst_n=0 asynchronously during a WAIT cycle of a write -> hready=1, hresp=OKAY, hrdata=0 immediately; the target register stays 0 after reset release.
- With AHB_SLV_HPROT_CHK_EN defined: write 0x4 with hprot=4'b0000 -> ERROR; with hprot=4'b0010 -> OKAY and the register is updated.
